// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings for the write-back stage: icodes, status codes and register IDs.
package y86_pkg;

  localparam int unsigned ICODE_W = 4;
  localparam int unsigned STAT_W  = 3;

  localparam logic [ICODE_W-1:0] IHALT   = 4'h0;
  localparam logic [ICODE_W-1:0] INOP    = 4'h1;
  localparam logic [ICODE_W-1:0] ICMOVXX = 4'h2;
  localparam logic [ICODE_W-1:0] IIRMOVQ = 4'h3;
  localparam logic [ICODE_W-1:0] IMRMOVQ = 4'h5;
  localparam logic [ICODE_W-1:0] IOPQ    = 4'h6;
  localparam logic [ICODE_W-1:0] ICALL   = 4'h8;
  localparam logic [ICODE_W-1:0] IRET    = 4'h9;
  localparam logic [ICODE_W-1:0] IPUSHQ  = 4'hA;
  localparam logic [ICODE_W-1:0] IPOPQ   = 4'hB;

  localparam logic [STAT_W-1:0] SAOK = 3'd1;
  localparam logic [STAT_W-1:0] SHLT = 3'd2;
  localparam logic [STAT_W-1:0] SADR = 3'd3;
  localparam logic [STAT_W-1:0] SINS = 3'd4;

  // Defaults for the 4-bit register-ID encoding
  localparam logic [3:0] RNONE = 4'hF;
  localparam logic [3:0] RSP   = 4'h4;

endpackage

// File: rtl/wb_regfile.sv
// Dual-write / dual-read register file; M port beats E port on a shared
// destination, and reads bypass the writes that will land on the next edge.
module wb_regfile #(
  parameter int unsigned DATA_W   = 64,
  parameter int unsigned REG_ID_W = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                we_e,
  input  logic [REG_ID_W-1:0] dst_e,
  input  logic [DATA_W-1:0]   val_e,
  input  logic                we_m,
  input  logic [REG_ID_W-1:0] dst_m,
  input  logic [DATA_W-1:0]   val_m,
  input  logic [REG_ID_W-1:0] src_a,
  input  logic [REG_ID_W-1:0] src_b,
  output logic [DATA_W-1:0]   val_a,
  output logic [DATA_W-1:0]   val_b
);

  localparam int unsigned NREGS = (1 << REG_ID_W) - 1;
  localparam logic [REG_ID_W-1:0] RNONE_ID = '1;

  logic [DATA_W-1:0] regs [NREGS];

  // Register writes; the M assignment comes last so it wins on a shared ID
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      if (we_e && (dst_e != RNONE_ID)) regs[dst_e] <= val_e;
      if (we_m && (dst_m != RNONE_ID)) regs[dst_m] <= val_m;
    end
  end

  // Read port A with bypass of pending writes, M over E
  always_comb begin
    val_a = '0;
    if (src_a != RNONE_ID) begin
      if (we_m && (src_a == dst_m))      val_a = val_m;
      else if (we_e && (src_a == dst_e)) val_a = val_e;
      else                               val_a = regs[src_a];
    end
  end

  // Read port B with bypass of pending writes, M over E
  always_comb begin
    val_b = '0;
    if (src_b != RNONE_ID) begin
      if (we_m && (src_b == dst_m))      val_b = val_m;
      else if (we_e && (src_b == dst_e)) val_b = val_e;
      else                               val_b = regs[src_b];
    end
  end

endmodule

// File: rtl/wb_stage_rf.sv
// Y86-64 write-back stage: M/W pipeline register, dstE/dstM decode,
// sticky halt and the register file. Optional retired-instruction counter
// is built when WB_RETIRE_CNT_EN is defined.
module wb_stage_rf #(
  parameter int unsigned DATA_W   = 64,
  parameter int unsigned REG_ID_W = 4,
  parameter int unsigned RSP_ID   = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                w_stall,
  input  logic                w_bubble,
  input  logic [2:0]          m_stat,
  input  logic [3:0]          m_icode,
  input  logic                m_cnd,
  input  logic [REG_ID_W-1:0] m_rA,
  input  logic [REG_ID_W-1:0] m_rB,
  input  logic [DATA_W-1:0]   m_valE,
  input  logic [DATA_W-1:0]   m_valM,
  input  logic [REG_ID_W-1:0] srcA,
  input  logic [REG_ID_W-1:0] srcB,
  output logic [DATA_W-1:0]   valA,
  output logic [DATA_W-1:0]   valB,
  output logic [REG_ID_W-1:0] w_dstE,
  output logic [REG_ID_W-1:0] w_dstM,
  output logic [DATA_W-1:0]   w_valE,
  output logic [DATA_W-1:0]   w_valM,
  output logic [2:0]          w_stat,
  output logic                halted,
  output logic [31:0]         retire_cnt
);
  import y86_pkg::*;

  localparam logic [REG_ID_W-1:0] RNONE_ID = '1;
  localparam logic [REG_ID_W-1:0] RSP_REG  = REG_ID_W'(RSP_ID);

  logic [REG_ID_W-1:0] dec_dste;
  logic [REG_ID_W-1:0] dec_dstm;
  logic                wr_en;

  // Destination decode of the instruction leaving memory
  always_comb begin
    dec_dste = RNONE_ID;
    dec_dstm = RNONE_ID;
    case (m_icode)
      ICMOVXX:             dec_dste = m_cnd ? m_rB : RNONE_ID;
      IIRMOVQ, IOPQ:       dec_dste = m_rB;
      IMRMOVQ:             dec_dstm = m_rA;
      ICALL, IRET, IPUSHQ: dec_dste = RSP_REG;
      IPOPQ: begin
        dec_dste = RSP_REG;
        dec_dstm = m_rA;
      end
      default: ;
    endcase
  end

  // W pipeline register: halt freezes, stall beats bubble
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_stat <= SAOK;
      w_dstE <= RNONE_ID;
      w_dstM <= RNONE_ID;
      w_valE <= '0;
      w_valM <= '0;
    end else if (halted || w_stall) begin
      w_stat <= w_stat;
    end else if (w_bubble) begin
      w_stat <= SAOK;
      w_dstE <= RNONE_ID;
      w_dstM <= RNONE_ID;
      w_valE <= '0;
      w_valM <= '0;
    end else begin
      w_stat <= m_stat;
      w_dstE <= dec_dste;
      w_dstM <= dec_dstm;
      w_valE <= m_valE;
      w_valM <= m_valM;
    end
  end

  // Sticky halt on any non-AOK status reaching W
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              halted <= 1'b0;
    else if (w_stat != SAOK) halted <= 1'b1;
  end

  assign wr_en = (w_stat == SAOK) && !halted;

  wb_regfile #(
    .DATA_W   (DATA_W),
    .REG_ID_W (REG_ID_W)
  ) u_regfile (
    .clk   (clk),
    .rst_n (rst_n),
    .we_e  (wr_en),
    .dst_e (w_dstE),
    .val_e (w_valE),
    .we_m  (wr_en),
    .dst_m (w_dstM),
    .val_m (w_valM),
    .src_a (srcA),
    .src_b (srcB),
    .val_a (valA),
    .val_b (valB)
  );

`ifdef WB_RETIRE_CNT_EN
  logic        w_valid;
  logic        w_first;
  logic [31:0] cnt_q;

  // Tracks whether W holds a real instruction and whether this is its first cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_valid <= 1'b0;
      w_first <= 1'b0;
    end else if (halted) begin
      w_valid <= w_valid;
    end else if (w_stall) begin
      w_first <= 1'b0;
    end else if (w_bubble) begin
      w_valid <= 1'b0;
      w_first <= 1'b0;
    end else begin
      w_valid <= 1'b1;
      w_first <= 1'b1;
    end
  end

  // Count each committing instruction once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                           cnt_q <= '0;
    else if (w_valid && w_first && wr_en) cnt_q <= cnt_q + 32'd1;
  end

  assign retire_cnt = cnt_q;
`else
  assign retire_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_wb_stage_rf.sv
// Bench for wb_stage_rf: directed vector table, hand-written stall/reset
// sequences and randomized traffic against a behavioural reference model.
module tb_wb_stage_rf;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        w_stall, w_bubble;
  logic [2:0]  m_stat;
  logic [3:0]  m_icode;
  logic        m_cnd;
  logic [3:0]  m_rA, m_rB;
  logic [63:0] m_valE, m_valM;
  logic [3:0]  srcA, srcB;
  logic [63:0] valA, valB;
  logic [3:0]  w_dstE, w_dstM;
  logic [63:0] w_valE, w_valM;
  logic [2:0]  w_stat;
  logic        halted;
  logic [31:0] retire_cnt;

  int checks = 0;
  int failures = 0;

  wb_stage_rf dut (
    .clk(clk), .rst_n(rst_n), .w_stall(w_stall), .w_bubble(w_bubble),
    .m_stat(m_stat), .m_icode(m_icode), .m_cnd(m_cnd), .m_rA(m_rA), .m_rB(m_rB),
    .m_valE(m_valE), .m_valM(m_valM), .srcA(srcA), .srcB(srcB),
    .valA(valA), .valB(valB), .w_dstE(w_dstE), .w_dstM(w_dstM),
    .w_valE(w_valE), .w_valM(w_valM), .w_stat(w_stat), .halted(halted),
    .retire_cnt(retire_cnt)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [63:0] ref_regs [15];
  logic [2:0]  ref_stat;
  logic [3:0]  ref_de, ref_dm;
  logic [63:0] ref_ve, ref_vm;
  logic        ref_halted;
  logic [31:0] ref_cnt;
  int          ref_seq, ref_last_counted, ref_next_seq;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void ref_reset();
    for (int i = 0; i < 15; i++) ref_regs[i] = 64'd0;
    ref_stat = 3'd1; ref_de = 4'hF; ref_dm = 4'hF; ref_ve = 64'd0; ref_vm = 64'd0;
    ref_halted = 1'b0; ref_cnt = 32'd0;
    ref_seq = 0; ref_last_counted = 0; ref_next_seq = 1;
  endfunction

  function automatic void ref_decode(input logic [3:0] ic, input logic cnd,
                                     input logic [3:0] ra, input logic [3:0] rb,
                                     output logic [3:0] de, output logic [3:0] dm);
    de = 4'hF; dm = 4'hF;
    if (ic == 4'h2 && cnd) de = rb;
    if (ic == 4'h3 || ic == 4'h6) de = rb;
    if (ic == 4'h5) dm = ra;
    if (ic == 4'h8 || ic == 4'h9 || ic == 4'hA || ic == 4'hB) de = 4'h4;
    if (ic == 4'hB) dm = ra;
  endfunction

  function automatic logic [63:0] ref_read(input logic [3:0] src);
    logic commit;
    commit = (ref_stat == 3'd1) && !ref_halted;
    if (src == 4'hF) return 64'd0;
    if (commit && src == ref_dm) return ref_vm;
    if (commit && src == ref_de) return ref_ve;
    return ref_regs[src];
  endfunction

  // Everything that happens at one rising edge, computed from the pre-edge state
  function automatic void ref_step();
    logic commit, was_halted;
    logic [3:0] de, dm;
    commit = (ref_stat == 3'd1) && !ref_halted;
    if (commit) begin
      if (ref_de != 4'hF) ref_regs[ref_de] = ref_ve;
      if (ref_dm != 4'hF) ref_regs[ref_dm] = ref_vm;
      if (ref_seq != 0 && ref_seq != ref_last_counted) begin
        ref_cnt = ref_cnt + 32'd1;
        ref_last_counted = ref_seq;
      end
    end
    was_halted = ref_halted;
    if (ref_stat != 3'd1) ref_halted = 1'b1;
    if (!was_halted && !w_stall) begin
      if (w_bubble) begin
        ref_stat = 3'd1; ref_de = 4'hF; ref_dm = 4'hF; ref_ve = 64'd0; ref_vm = 64'd0;
        ref_seq = 0;
      end else begin
        ref_decode(m_icode, m_cnd, m_rA, m_rB, de, dm);
        ref_stat = m_stat; ref_de = de; ref_dm = dm; ref_ve = m_valE; ref_vm = m_valM;
        ref_seq = ref_next_seq;
        ref_next_seq++;
      end
    end
  endfunction

  task automatic check_all(input string tag);
    logic [31:0] exp_cnt;
`ifdef WB_RETIRE_CNT_EN
    exp_cnt = ref_cnt;
`else
    exp_cnt = 32'd0;
`endif
    chk({tag, ".valA"}, valA, ref_read(srcA));
    chk({tag, ".valB"}, valB, ref_read(srcB));
    chk({tag, ".w_dstE"}, 64'(w_dstE), 64'(ref_de));
    chk({tag, ".w_dstM"}, 64'(w_dstM), 64'(ref_dm));
    chk({tag, ".w_valE"}, w_valE, ref_ve);
    chk({tag, ".w_valM"}, w_valM, ref_vm);
    chk({tag, ".w_stat"}, 64'(w_stat), 64'(ref_stat));
    chk({tag, ".halted"}, 64'(halted), 64'(ref_halted));
    chk({tag, ".retire_cnt"}, 64'(retire_cnt), 64'(exp_cnt));
  endtask

  task automatic tick();
    @(posedge clk);
    ref_step();
    #2;
  endtask

  task automatic drive(input logic st, input logic bb, input logic [2:0] stat,
                       input logic [3:0] ic, input logic cnd, input logic [3:0] ra,
                       input logic [3:0] rb, input logic [63:0] ve, input logic [63:0] vm,
                       input logic [3:0] sa, input logic [3:0] sb);
    w_stall = st; w_bubble = bb; m_stat = stat; m_icode = ic; m_cnd = cnd;
    m_rA = ra; m_rB = rb; m_valE = ve; m_valM = vm; srcA = sa; srcB = sb;
  endtask

  typedef struct {
    logic        st, bb;
    logic [2:0]  stat;
    logic [3:0]  ic;
    logic        cnd;
    logic [3:0]  ra, rb;
    logic [63:0] ve, vm;
    logic [3:0]  sa, sb;
    logic [3:0]  ex_de, ex_dm;
    logic [63:0] ex_a, ex_b;
    logic        ex_halt;
  } vec_t;

  function automatic vec_t mk(input logic st, input logic bb, input logic [2:0] stat,
                              input logic [3:0] ic, input logic cnd, input logic [3:0] ra,
                              input logic [3:0] rb, input logic [63:0] ve, input logic [63:0] vm,
                              input logic [3:0] sa, input logic [3:0] sb,
                              input logic [3:0] ex_de, input logic [3:0] ex_dm,
                              input logic [63:0] ex_a, input logic [63:0] ex_b, input logic ex_halt);
    vec_t v;
    v.st = st; v.bb = bb; v.stat = stat; v.ic = ic; v.cnd = cnd; v.ra = ra; v.rb = rb;
    v.ve = ve; v.vm = vm; v.sa = sa; v.sb = sb; v.ex_de = ex_de; v.ex_dm = ex_dm;
    v.ex_a = ex_a; v.ex_b = ex_b; v.ex_halt = ex_halt;
    return v;
  endfunction

  vec_t tbl [14];

  initial begin
    // Each row: inputs for one cycle, then W/read values expected just after that edge
    tbl[0]  = mk(0,0,1,4'h3,0,4'hF,4'h2,64'h1234,64'h0,  4'h2,4'hF, 4'h2,4'hF,64'h1234,64'h0,   0);
    tbl[1]  = mk(0,0,1,4'h1,0,4'hF,4'hF,64'h0,   64'h0,  4'h2,4'h3, 4'hF,4'hF,64'h1234,64'h0,   0);
    tbl[2]  = mk(0,0,1,4'h2,0,4'hF,4'h3,64'h99,  64'h0,  4'h3,4'h2, 4'hF,4'hF,64'h0,   64'h1234,0);
    tbl[3]  = mk(0,0,1,4'h2,1,4'hF,4'h3,64'h55,  64'h0,  4'h3,4'h2, 4'h3,4'hF,64'h55,  64'h1234,0);
    tbl[4]  = mk(0,0,1,4'h1,0,4'hF,4'hF,64'h0,   64'h0,  4'h3,4'h4, 4'hF,4'hF,64'h55,  64'h0,   0);
    tbl[5]  = mk(0,0,1,4'hB,0,4'h4,4'hF,64'h108, 64'hABC,4'h4,4'hF, 4'h4,4'h4,64'hABC, 64'h0,   0);
    tbl[6]  = mk(0,0,1,4'hB,0,4'h3,4'hF,64'h100, 64'h77, 4'h4,4'h3, 4'h4,4'h3,64'h100, 64'h77,  0);
    tbl[7]  = mk(0,0,1,4'h1,0,4'hF,4'hF,64'h0,   64'h0,  4'h4,4'h3, 4'hF,4'hF,64'h100, 64'h77,  0);
    tbl[8]  = mk(0,0,1,4'h3,0,4'hF,4'h5,64'h11,  64'h0,  4'h5,4'h2, 4'h5,4'hF,64'h11,  64'h1234,0);
    tbl[9]  = mk(1,1,1,4'h3,0,4'hF,4'h6,64'h22,  64'h0,  4'h5,4'h6, 4'h5,4'hF,64'h11,  64'h0,   0);
    tbl[10] = mk(0,1,1,4'h3,0,4'hF,4'h6,64'h22,  64'h0,  4'h5,4'h6, 4'hF,4'hF,64'h11,  64'h0,   0);
    tbl[11] = mk(0,0,3,4'h5,0,4'h7,4'hF,64'h0,   64'h33, 4'h7,4'h5, 4'hF,4'h7,64'h0,   64'h11,  0);
    tbl[12] = mk(0,0,1,4'h6,0,4'hF,4'h8,64'h44,  64'h0,  4'h7,4'h8, 4'h8,4'hF,64'h0,   64'h0,   1);
    tbl[13] = mk(0,0,1,4'h6,0,4'hF,4'h9,64'h66,  64'h0,  4'h8,4'h9, 4'h8,4'hF,64'h0,   64'h0,   1);

    // Reset state
    rst_n = 1'b0;
    drive(0,0,1,4'h1,0,4'hF,4'hF,64'h0,64'h0,4'hF,4'hF);
    ref_reset();
    #12;
    chk("rst.w_dstE", 64'(w_dstE), 64'hF);
    chk("rst.w_dstM", 64'(w_dstM), 64'hF);
    chk("rst.w_stat", 64'(w_stat), 64'd1);
    chk("rst.halted", 64'(halted), 64'd0);
    chk("rst.retire_cnt", 64'(retire_cnt), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #2;

    // Directed vector table
    for (int i = 0; i < 14; i++) begin
      drive(tbl[i].st, tbl[i].bb, tbl[i].stat, tbl[i].ic, tbl[i].cnd, tbl[i].ra, tbl[i].rb,
            tbl[i].ve, tbl[i].vm, tbl[i].sa, tbl[i].sb);
      tick();
      chk($sformatf("vec%0d.w_dstE", i), 64'(w_dstE), 64'(tbl[i].ex_de));
      chk($sformatf("vec%0d.w_dstM", i), 64'(w_dstM), 64'(tbl[i].ex_dm));
      chk($sformatf("vec%0d.valA", i), valA, tbl[i].ex_a);
      chk($sformatf("vec%0d.valB", i), valB, tbl[i].ex_b);
      chk($sformatf("vec%0d.halted", i), 64'(halted), 64'(tbl[i].ex_halt));
      check_all($sformatf("vec%0d", i));
    end

    // Asynchronous reset pulse in the middle of a cycle clears at once
    drive(0,0,1,4'h1,0,4'hF,4'hF,64'h0,64'h0,4'h5,4'h3);
    #1;
    rst_n = 1'b0;
    ref_reset();
    #1;
    chk("arst.halted", 64'(halted), 64'd0);
    chk("arst.w_dstE", 64'(w_dstE), 64'hF);
    chk("arst.w_stat", 64'(w_stat), 64'd1);
    chk("arst.r5", valA, 64'd0);
    chk("arst.r3", valB, 64'd0);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #2;

    // Stalled instruction is held, rewritten idempotently, and retired once
    drive(0,0,1,4'h3,0,4'hF,4'h1,64'hAA,64'h0,4'h1,4'hF);
    tick();
    check_all("stall0");
    for (int k = 0; k < 3; k++) begin
      drive(1,0,1,4'h6,0,4'hF,4'h2,64'h5A5A + 64'(k),64'h0,4'h1,4'h2);
      tick();
      chk($sformatf("stall%0d.w_valE", k + 1), w_valE, 64'hAA);
      check_all($sformatf("stall%0d", k + 1));
    end
    drive(0,1,1,4'h3,0,4'hF,4'h2,64'h0,64'h0,4'h1,4'h2);
    tick();
    check_all("stall_bubble");

    // Randomized traffic against the reference model
    for (int n = 0; n < 600; n++) begin
      logic [2:0] st;
      st = ($urandom_range(0, 59) == 0) ? 3'($urandom_range(2, 4)) : 3'd1;
      drive(($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0), st,
            4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
            4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
            {$urandom, $urandom}, {$urandom, $urandom},
            4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      #1;
      check_all("rnd");
      if (ref_halted && $urandom_range(0, 7) == 0) begin
        rst_n = 1'b0;
        ref_reset();
        #1;
        rst_n = 1'b1;
        check_all("rnd_rst");
      end
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
